// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle LA32R load/store unit with alignment check and sub-word read-modify-write.
// Define MEM_ACCESS_BYTE_WE_EN for a byte-strobed RAM (adds ram_wstrb, removes the RMW phase).
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_AWIDTH  = 16,
  parameter int RAM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_ale,
  output logic [RAM_AWIDTH-1:0] ram_a,
  output logic [31:0]           ram_d,
  output logic                  ram_we,
  input  logic [31:0]           ram_spo
`ifdef MEM_ACCESS_BYTE_WE_EN
  ,
  output logic [3:0]            ram_wstrb
`endif
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t                r_state, w_next;
  logic                  r_we, r_uns, r_ale;
  logic [1:0]            r_size, r_lane, r_cnt;
  logic [31:0]           r_word, r_ram_d;
  logic [RAM_AWIDTH-1:0] r_ram_a;
  logic                  w_acc, w_ale, w_last, w_direct;
  logic [7:0]            w_b;
  logic [15:0]           w_h;
  logic [31:0]           w_ext;
`ifdef MEM_ACCESS_BYTE_WE_EN
  logic [3:0]            r_strb;
  assign w_direct = req_we;
`else
  logic [15:0]           r_wdata;
  logic [31:0]           w_merge;
  assign w_direct = req_we && req_size == 2'd2;
  // replace only the addressed lane of the freshly read word
  assign w_merge = r_size == 2'd0
    ? (ram_spo & ~(32'hFF << {r_lane, 3'b0})) | (32'(r_wdata[7:0]) << {r_lane, 3'b0})
    : (ram_spo & ~(32'hFFFF << {r_lane[1], 4'b0})) | (32'(r_wdata) << {r_lane[1], 4'b0});
`endif
  assign w_acc  = req_valid && r_state == IDLE;
  assign w_ale  = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign w_last = r_state == READ && r_cnt == 2'(RAM_LATENCY);
  assign w_b    = 8'(r_word >> {r_lane, 3'b0});
  assign w_h    = 16'(r_word >> {r_lane[1], 4'b0});
  assign w_ext  = r_size == 2'd0 ? {{24{~r_uns & w_b[7]}}, w_b} :
                  r_size == 2'd1 ? {{16{~r_uns & w_h[15]}}, w_h} : r_word;
  always_comb begin
    w_next     = r_state;
    req_ready  = r_state == IDLE;
    resp_valid = r_state == RESP;
    resp_ale   = r_state == RESP && r_ale;
    resp_rdata = (r_state == RESP && !r_ale && !r_we) ? w_ext : 32'd0;
    ram_we     = r_state == WRITE;
    ram_a      = r_ram_a;
    ram_d      = r_ram_d;
`ifdef MEM_ACCESS_BYTE_WE_EN
    ram_wstrb  = r_state == WRITE ? r_strb : 4'd0;
`endif
    case (r_state)
      IDLE:    w_next = !w_acc ? IDLE : w_ale ? RESP : w_direct ? WRITE : READ;
      READ:    w_next = !w_last ? READ : r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_ale   <= 1'b0;
      r_size  <= 2'd0;
      r_lane  <= 2'd0;
      r_cnt   <= 2'd0;
      r_word  <= 32'd0;
      r_ram_d <= 32'd0;
      r_ram_a <= '0;
`ifdef MEM_ACCESS_BYTE_WE_EN
      r_strb  <= 4'd0;
`else
      r_wdata <= 16'd0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == READ) r_cnt <= r_cnt + 2'd1;
      if (w_acc) begin
        r_we   <= req_we;
        r_size <= req_size;
        r_uns  <= req_unsigned;
        r_lane <= req_addr[1:0];
        r_ale  <= w_ale;
        r_cnt  <= 2'd0;
        if (!w_ale) r_ram_a <= RAM_AWIDTH'(req_addr[ADDR_WIDTH-1:2]);
`ifdef MEM_ACCESS_BYTE_WE_EN
        if (!w_ale && req_we) begin
          r_ram_d <= req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                     req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
          r_strb  <= req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                     req_size == 2'd1 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
        end
`else
        r_wdata <= req_wdata[15:0];
        if (!w_ale && w_direct) r_ram_d <= req_wdata;
`endif
      end
      if (w_last) begin
        r_word <= ram_spo;
`ifndef MEM_ACCESS_BYTE_WE_EN
        if (r_we) r_ram_d <= w_merge;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a latency-aware RAM model and a spec-level reference memory.
module tb_mem_access_unit;
  localparam int LAT = 2;
`ifdef MEM_ACCESS_BYTE_WE_EN
  localparam bit BWE = 1'b1;
`else
  localparam bit BWE = 1'b0;
`endif
  typedef struct { logic ale; logic [31:0] rd; int lat; logic [15:0] a; int acc; } rexp_t;
  typedef struct { logic [15:0] a; logic [31:0] d; logic [3:0] s; } wexp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_wdata = 32'd0;
  logic req_ready, resp_valid, resp_ale, ram_we;
  logic [31:0] resp_rdata, ram_d, ram_spo;
  logic [15:0] ram_a;
`ifdef MEM_ACCESS_BYTE_WE_EN
  logic [3:0] ram_wstrb;
`endif

  mem_access_unit #(.ADDR_WIDTH(16), .RAM_AWIDTH(16), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ale(resp_ale),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
`ifdef MEM_ACCESS_BYTE_WE_EN
    , .ram_wstrb(ram_wstrb)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0, chg = 0, total = 0, bad = 0;
  logic [15:0] last_a = 16'd0;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  bit init = 1'b0;
  rexp_t rq[$];
  wexp_t wq[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(ram_a) chg = cyc;
  // data is only trustworthy once ram_a has been stable for LAT cycles
  assign ram_spo = (cyc - chg >= LAT) ? mem[ram_a[5:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (!init) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
      init <= 1'b1;
    end else if (ram_we) begin
`ifdef MEM_ACCESS_BYTE_WE_EN
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_a[5:0]][8*b +: 8] <= ram_d[8*b +: 8];
`else
      mem[ram_a[5:0]] <= ram_d;
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rexp_t e;
    wexp_t w;
    if (!rst && resp_valid) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_resp: got resp_valid=1 want no response pending");
      end else begin
        e = rq.pop_front();
        chk("resp_ale", {31'd0, resp_ale}, {31'd0, e.ale});
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_latency", cyc - e.acc, e.lat);
        chk("resp_ram_a", {16'd0, ram_a}, {16'd0, e.a});
      end
    end
    if (!rst && ram_we) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_write: got ram_we=1 at a=%h want no write pending", ram_a);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {16'd0, ram_a}, {16'd0, w.a});
        chk("wr_data", ram_d, w.d);
`ifdef MEM_ACCESS_BYTE_WE_EN
        chk("wr_strb", {28'd0, ram_wstrb}, {28'd0, w.s});
`endif
      end
    end
  end

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input int b);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * b)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (b / 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [15:0] ad, input logic [31:0] wd, input bit track);
    rexp_t r;
    wexp_t w;
    logic [31:0] old, nw;
    int n, b, idx;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got req_ready=0 want 1 within 50 cycles");
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = ad; req_wdata = wd;
    b = int'(ad[1:0]);
    idx = int'(ad[7:2]);
    old = ref_mem[idx];
    r.ale = sz == 2'd3 || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
    r.acc = cyc;
    r.rd = 32'd0;
    if (!r.ale) last_a = ad >> 2;
    r.a = last_a;
    if (r.ale) r.lat = 1;
    else if (we) begin
      nw = old;
      if (sz == 2'd0) nw[8 * b +: 8] = wd[7:0];
      else if (sz == 2'd1) nw[16 * (b / 2) +: 16] = wd[15:0];
      else nw = wd;
      if (track) ref_mem[idx] = nw;
      r.lat = (BWE || sz == 2'd2) ? 2 : LAT + 3;
      w.a = ad >> 2;
      w.d = !BWE ? nw : sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
      w.s = sz == 2'd0 ? 4'b0001 << b : sz == 2'd1 ? 4'b0011 << (b & 2) : 4'b1111;
      wq.push_back(w);
    end else begin
      r.lat = LAT + 2;
      r.rd = load_val(old, sz, uns, b);
    end
    if (track) rq.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = 16'($urandom); req_wdata = $urandom; req_unsigned = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin @(negedge clk); n++; end
    chk("drain_resp_q", rq.size(), 0);
    chk("drain_write_q", wq.size(), 0);
  endtask

  initial begin
    int n;
    logic [31:0] saved;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_ale", {31'd0, resp_ale}, 32'd0);
    chk("rst_ram_a", {16'd0, ram_a}, 32'd0);
    chk("rst_ram_d", ram_d, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    rst = 1'b0;
    issue(1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, 1);
    issue(0, 2'd2, 0, 16'h0010, 32'h0, 1);
    issue(1, 2'd2, 0, 16'h0020, 32'h80FF7F01, 1);
    issue(0, 2'd0, 0, 16'h0023, 32'h0, 1);
    issue(0, 2'd0, 1, 16'h0023, 32'h0, 1);
    issue(0, 2'd1, 0, 16'h0022, 32'h0, 1);
    issue(0, 2'd1, 1, 16'h0020, 32'h0, 1);
    issue(1, 2'd2, 0, 16'h0020, 32'h11223344, 1);
    issue(1, 2'd0, 0, 16'h0021, 32'hFFFFFFAA, 1);
    issue(0, 2'd2, 0, 16'h0020, 32'h0, 1);
    issue(0, 2'd2, 0, 16'h0002, 32'h0, 1);
    issue(1, 2'd1, 0, 16'h0001, 32'h5555, 1);
    issue(0, 2'd3, 0, 16'h0000, 32'h0, 1);
    issue(1, 2'd1, 0, 16'h0032, 32'h00001234, 1);
    issue(0, 2'd2, 0, 16'h0030, 32'h0, 1);
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            1'($urandom), 16'($urandom_range(0, 255)), $urandom, 1);
    end
    drain();
    // abort a sub-word store in its write cycle; the RAM word must survive
    issue(1, 2'd0, 0, 16'h0045, 32'h0000005A, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_we && n < 20);
    chk("rst_reach_write", {31'd0, ram_we}, 32'd1);
    saved = ref_mem[17];
    #1 rst = 1'b1;
    #1;
    chk("async_ram_we", {31'd0, ram_we}, 32'd0);
    chk("async_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 chk("rst_word_intact", mem[17], saved);
    @(negedge clk);
    rst = 1'b0;
    last_a = 16'd0;
    chk("post_rst_ram_a", {16'd0, ram_a}, 32'd0);
    issue(0, 2'd2, 0, 16'h0044, 32'h0, 1);
    issue(1, 2'd1, 0, 16'h0046, 32'h0000BEEF, 1);
    issue(0, 2'd2, 0, 16'h0044, 32'h0, 1);
    drain();
    for (int i = 0; i < 64; i++) chk("mem_word", mem[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle LA32R data-memory access unit between the MEM stage and a word-organised data RAM.
- Replaces the single-cycle combinational read/write mux with a request/response FSM.
- Supports byte, half and word loads (signed and unsigned) and stores, with alignment checking.
- Supports configurable RAM read latency; sub-word stores use read-modify-write when the RAM has only a word write enable.

Parameters:
- ADDR_WIDTH, 16: valid byte-address bits of req_addr.
- RAM_AWIDTH, 16: width of ram_a. Holds the word index addr[ADDR_WIDTH-1:2], zero-extended. Must be at least ADDR_WIDTH-2.
- RAM_LATENCY, 0: cycles from ram_a stable until ram_spo is valid. Range 0..3; 0 means distributed/combinational RAM.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_ale  out  1  address-alignment / illegal-size error, qualified by resp_valid
- ram_a  out  RAM_AWIDTH  RAM word address
- ram_d  out  32  RAM write data
- ram_we  out  1  RAM word write enable
- ram_spo  in  32  RAM read data

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_ale=0; ram_a=0; ram_d=0; ram_we=0.
- Reset is asynchronous at any point: ram_we and resp_valid drop immediately, the in-flight request is discarded, and no partial write occurs after reset asserts.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - The request fields are registered at acceptance; inputs are don't-care afterwards.
  - req_ready=1 only in IDLE, so at most one request is outstanding.
  - resp_valid has no backpressure.
- States: IDLE, READ, WRITE, RESP.
- Alignment check, applied at acceptance:
  - half requires addr[0]=0; word requires addr[1:0]=0; size=3 is always an error.
  - On error: go to RESP with resp_ale=1, resp_rdata=0, and no RAM access (ram_we stays 0; ram_a keeps its previous value).
- Word store:
  - IDLE -> WRITE (ram_we=1, ram_a=word index, ram_d=wdata) -> RESP.
  - resp_valid 2 cycles after acceptance.
- Load:
  - IDLE -> READ, held for RAM_LATENCY+1 cycles with ram_a stable; ram_spo is sampled on the last READ cycle.
  - READ -> RESP; resp_valid RAM_LATENCY+2 cycles after acceptance.
- Load extraction (little-endian):
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits by zero or by the lane MSB, per req_unsigned.
  - Word loads ignore req_unsigned.
- Sub-word store (read-modify-write):
  - IDLE -> READ (as for loads) -> WRITE -> RESP.
  - ram_d = sampled word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other bytes unchanged.
  - resp_valid RAM_LATENCY+3 cycles after acceptance.
- RESP lasts one cycle, then IDLE. A new request can be accepted on the cycle after RESP.
- ram_a holds its last value while IDLE.
- ram_we is high only in WRITE, exactly one cycle per store.
- Address bits at or above ADDR_WIDTH are not present; ram_a upper bits are 0.

Optional Feature:
- Macro: MEM_ACCESS_BYTE_WE_EN.
- Defined:
  - Adds output port ram_wstrb (4 bits); ram_we stays the write qualifier.
  - All stores take the word-store path (latency 2, no READ phase).
  - ram_d carries wdata replicated into every lane (byte x4, half x2).
  - ram_wstrb = 4'b0001<<addr[1:0] for byte, 4'b0011<<{addr[1],1'b0} for half, 4'b1111 for word; 0 outside WRITE.
- Undefined: port absent; read-modify-write as above.

Test Plan:
- RAM_LATENCY=0; word store 0xDEADBEEF at 0x0010, then word load at 0x0010 -> ram_we pulses once with ram_a=4; load resp_valid 2 cycles after acceptance with rdata=0xDEADBEEF.
- Word 0x80FF7F01 at 0x0020; loads LB@0x0023, LBU@0x0023, LH@0x0022, LHU@0x0020 -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x00007F01.
- RAM_LATENCY=2; SB 0xAA at 0x0021 onto 0x11223344 -> exactly one write, ram_d=0x1122AA44; resp_valid 5 cycles after acceptance; ram_we never high during READ.
- LW@0x0002, SH@0x0001, size=3 @0x0000 -> resp_valid 1 cycle after acceptance, resp_ale=1, rdata=0, ram_we=0 throughout.
- Assert rst during the WRITE cycle of a sub-word store -> ram_we drops without waiting for a clock edge; RAM word is unchanged if rst precedes the edge; state IDLE, req_ready=1; the next request completes normally.
- MEM_ACCESS_BYTE_WE_EN defined; SH 0x1234 at 0x0032 -> latency 2, ram_d=0x12341234, ram_wstrb=4'b1100, ram_spo not sampled.
